deu_gpr_wb_arb: RTL and testbench
=================================

Name: deu_gpr_wb_arb

Overview:
- Write-side driver for the decode-unit GPR file: collects results from NSRC execution sources and issues them onto the GPR file's three write ports (we0..2 / waddr0..2 / wdata0..2).
- Each source gets a small FIFO behind a valid/ready handshake.
- A round-robin arbiter grants up to three FIFO heads per cycle. Same-address collisions within a cycle are never issued, and writes to r0 are dropped.
- Sits between the execution-unit result buses and the GPR file.

Parameters:
- NSRC, 4, number of result sources (alu0, alu1, muldiv, lsu); legal range 3..8.
- DEPTH, 2, per-source FIFO entries; power of two, at least 2.
- NWP, 3, GPR write ports driven; fixed at 3 to match the GPR file.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- src_valid  in  NSRC  per-source result valid.
- src_ready  out  NSRC  per-source FIFO not full.
- src_waddr  in  NSRC x `LA64_ARF_SEL  destination register per source.
- src_wdata  in  NSRC x `LA64_DATA_WIDTH  result data per source.
- we  out  NWP  write enable to GPR write ports 0..2.
- waddr  out  NWP x `LA64_ARF_SEL  write addresses.
- wdata  out  NWP x `LA64_DATA_WIDTH  write data.
- busy  out  1  some FIFO non-empty or some we asserted.

Behaviour:
- Reset: one clk edge with rst=1. Clears all FIFOs (pointers and counts to 0), rr_ptr=0, and we/waddr/wdata=0. src_ready=1 and busy=0 from the cycle after reset.
- Reset mid-operation discards all queued and in-flight writes; no write port fires in the cycle after reset.
- Accept: a source entry is enqueued on a clk edge when src_valid[i]&src_ready[i]. src_ready[i] = !full[i], registered-count based. No combinational ready from same-cycle dequeue.
- Per-source FIFO preserves order; enqueue and dequeue in the same cycle are both legal when full or empty.
- Arbitration runs each cycle over the FIFO heads, scanning sources from rr_ptr upward, modulo NSRC.
- Head with waddr==0: dequeued without using a write port (drop). This does not count toward the 3-grant limit.
- Head with waddr!=0: granted if fewer than NWP grants so far this cycle and its waddr differs from every waddr already granted this cycle. Otherwise it stalls, stays at the head, and is retried next cycle.
- Grant k (in scan order) is assigned to write port k; ports above the grant count carry we=0.
- Outputs are registered: we/waddr/wdata update on the edge that dequeues the granted entries. When we[k]=0, waddr[k] and wdata[k] are held at 0.
- Latency: accept on edge t, then we asserted in cycle t+2 minimum. Throughput is 3 writes/cycle sustained.
- rr_ptr: after a cycle with at least one grant, becomes (index of last granted source + 1) mod NSRC. With no grant it is unchanged. Drops do not move rr_ptr.
- Guarantees:
  - no two asserted write ports in one cycle share a waddr;
  - we never asserted with waddr==0;
  - per-source program order of writes.
- Cross-source WAW ordering is not guaranteed; upstream rename/scoreboard prevents it.
- Widths: all addresses are `LA64_ARF_SEL bits and data is `LA64_DATA_WIDTH bits, with no truncation or extension.
- busy = |fifo_nonempty | (|we).

Decomposition:
- Shared package (deu_pkg): wb_req_t struct {waddr, wdata} and the constant NWP=3.
- `LA64_ARF_SEL and `LA64_DATA_WIDTH come from constants.vh.
- Sub-module: deu_wb_fifo (synchronous FIFO, DEPTH entries, wb_req_t payload, full/empty/push/pop, active-high sync reset), instantiated NSRC times via generate.
- Arbiter and output registers live in the top module.

Test Plan:
- Single write: src0 sends waddr=5, wdata=0x1234 at cycle 1 -> cycle 3 shows we=3'b001, waddr0=5, wdata0=0x1234; busy=0 in cycle 4.
- Four-way burst: src0..3 each send one write in the same cycle to regs 1,2,3,4 with rr_ptr=0 -> next-but-one cycle shows we=3'b111 for regs 1,2,3; the following cycle shows we=3'b001 for reg 4; rr_ptr=3 after the first grant.
- Collision: src0 and src1 both target reg 7 (data 0xA, 0xB) in the same cycle -> 0xA written first, 0xB one cycle later, never both in one cycle.
- r0 drop: src2 sends waddr=0, wdata=0xFFFF -> no we asserted, FIFO drains, busy falls to 0, src_ready stays 1.
- Backpressure: hold src_valid[1]=1 with four distinct regs while src0/2/3 saturate the ports -> src_ready[1]=0 once 2 entries are queued; no entry lost; order preserved.
- Reset mid-burst: rst=1 with 2 entries queued per source -> the following cycle has we=0, src_ready all 1, busy=0, and no queued data is ever written.

Source files
------------

// File: rtl/deu_pkg.sv
// Shared types for the decode-unit GPR write-back path.
// Address/data widths fall back to LA64 defaults when constants.vh has not defined them.
`ifndef LA64_ARF_SEL
`define LA64_ARF_SEL 5
`endif
`ifndef LA64_DATA_WIDTH
`define LA64_DATA_WIDTH 64
`endif

package deu_pkg;

   localparam int ARF_SEL_W = `LA64_ARF_SEL;
   localparam int DATA_W    = `LA64_DATA_WIDTH;
   localparam int NWP       = 3;

   typedef struct packed {
      logic [ARF_SEL_W-1:0] waddr;
      logic [DATA_W-1:0]    wdata;
   } wb_req_t;

endpackage

// File: rtl/deu_gpr_wb_arb_if.sv
// Result-source handshake and GPR write-port bundle for deu_gpr_wb_arb.
// master = execution side / bench, slave = the write-back arbiter.
interface deu_gpr_wb_arb_if #(
   parameter int NSRC = 4
);
   import deu_pkg::*;

   logic [NSRC-1:0]                 src_valid;
   logic [NSRC-1:0]                 src_ready;
   logic [NSRC-1:0][ARF_SEL_W-1:0]  src_waddr;
   logic [NSRC-1:0][DATA_W-1:0]     src_wdata;
   logic [NWP-1:0]                  we;
   logic [NWP-1:0][ARF_SEL_W-1:0]   waddr;
   logic [NWP-1:0][DATA_W-1:0]      wdata;
   logic                            busy;

   modport master (
      output src_valid, src_waddr, src_wdata,
      input  src_ready, we, waddr, wdata, busy
   );

   modport slave (
      input  src_valid, src_waddr, src_wdata,
      output src_ready, we, waddr, wdata, busy
   );

endinterface

// File: rtl/deu_wb_fifo.sv
// Per-source result FIFO: DEPTH entries of wb_req_t, head exposed combinationally.
// Pointers and count reset; storage does not.
module deu_wb_fifo
   import deu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   wb_req_t             mem [DEPTH];
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W:0]      count;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/deu_gpr_wb_arb.sv
// GPR write-back arbiter: NSRC result FIFOs feed three GPR write ports through a
// round-robin, collision-free grant; r0 writes are silently dropped.
module deu_gpr_wb_arb
   import deu_pkg::*;
#(
   parameter int NSRC  = 4,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   deu_gpr_wb_arb_if.slave    bus
);

   localparam int RR_W = $clog2(NSRC);
   localparam int NG_W = $clog2(NWP + 1);
   localparam logic [RR_W:0]   NSRC_W = (RR_W+1)'(NSRC);
   localparam logic [NG_W-1:0] NWP_W  = NG_W'(NWP);

   wb_req_t [NSRC-1:0]  din_p0;
   wb_req_t [NSRC-1:0]  head_p0;
   logic    [NSRC-1:0]  full_p0;
   logic    [NSRC-1:0]  empty_p0;
   logic    [NSRC-1:0]  push_p0;
   logic    [NSRC-1:0]  pop_p0;

   logic [RR_W-1:0]     rr_ptr_p0;
   logic [RR_W-1:0]     rr_nxt;
   logic [RR_W:0]       scan_sum;
   logic [RR_W-1:0]     scan_idx;
   logic [RR_W:0]       nxt_sum;
   logic [NG_W-1:0]     ngrant;
   logic                clash;

   logic    [NWP-1:0]   we_nxt;
   wb_req_t [NWP-1:0]   port_nxt;
   logic    [NWP-1:0]   we_p1;
   wb_req_t [NWP-1:0]   port_p1;

   // ---- stage p0: per-source FIFOs (enqueue on the accept edge)
   for (genvar g = 0; g < NSRC; g++) begin : g_src
      assign din_p0[g]  = '{waddr: bus.src_waddr[g], wdata: bus.src_wdata[g]};
      assign push_p0[g] = bus.src_valid[g] & ~full_p0[g];

      deu_wb_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push_p0[g]),
         .pop   (pop_p0[g]),
         .din   (din_p0[g]),
         .head  (head_p0[g]),
         .full  (full_p0[g]),
         .empty (empty_p0[g])
      );
   end

   assign bus.src_ready = ~full_p0;

   // Scan heads from rr_ptr; each grant takes the next free port unless its
   // address is already claimed this cycle. r0 heads just retire.
   always_comb begin
      pop_p0   = '0;
      we_nxt   = '0;
      port_nxt = '0;
      rr_nxt   = rr_ptr_p0;
      ngrant   = '0;
      scan_sum = '0;
      scan_idx = '0;
      nxt_sum  = '0;
      clash    = 1'b0;
      for (int j = 0; j < NSRC; j++) begin
         scan_sum = {1'b0, rr_ptr_p0} + (RR_W+1)'(j);
         if (scan_sum >= NSRC_W) scan_sum = scan_sum - NSRC_W;
         scan_idx = scan_sum[RR_W-1:0];
         if (!empty_p0[scan_idx]) begin
            if (head_p0[scan_idx].waddr == '0) begin
               pop_p0[scan_idx] = 1'b1;
            end else if (ngrant < NWP_W) begin
               clash = 1'b0;
               for (int k = 0; k < NWP; k++) begin
                  if ((NG_W'(k) < ngrant) && (port_nxt[k].waddr == head_p0[scan_idx].waddr))
                     clash = 1'b1;
               end
               if (!clash) begin
                  port_nxt[ngrant] = head_p0[scan_idx];
                  we_nxt[ngrant]   = 1'b1;
                  pop_p0[scan_idx] = 1'b1;
                  ngrant           = ngrant + NG_W'(1);
                  nxt_sum          = {1'b0, scan_idx} + (RR_W+1)'(1);
                  rr_nxt           = (nxt_sum == NSRC_W) ? '0 : nxt_sum[RR_W-1:0];
               end
            end
         end
      end
   end

   // ---- stage p1: registered write ports
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_p0 <= '0;
         we_p1     <= '0;
         port_p1   <= '0;
      end else begin
         rr_ptr_p0 <= rr_nxt;
         we_p1     <= we_nxt;
         port_p1   <= port_nxt;
      end
   end

   for (genvar k = 0; k < NWP; k++) begin : g_port
      assign bus.waddr[k] = port_p1[k].waddr;
      assign bus.wdata[k] = port_p1[k].wdata;
   end

   assign bus.we   = we_p1;
   assign bus.busy = (|(~empty_p0)) | (|we_p1);

endmodule

// File: tb/tb_deu_gpr_wb_arb.sv
// Bench for deu_gpr_wb_arb: vector table of one-cycle injections with expected grant
// sequences, a per-source scoreboard on every write port, and multi-cycle sequences.
module tb_deu_gpr_wb_arb;
   import deu_pkg::*;

   localparam int NSRC  = 4;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   deu_gpr_wb_arb_if #(.NSRC(NSRC)) bus ();

   deu_gpr_wb_arb #(
      .NSRC  (NSRC),
      .DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;
   logic [NSRC-1:0] last_acc;
   wb_req_t exp_q [NSRC][$];

   typedef struct packed {
      logic [3:0]                 vld;
      logic [3:0][ARF_SEL_W-1:0]  addr;
      logic [3:0][31:0]           dat;
      logic [2:0][1:0]            n;
      logic [2:0][2:0][1:0]       src;
   } vec_t;

   vec_t vt_tab [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] tag(input int s, input logic [31:0] lo);
      return DATA_W'({8'(s), 24'h0, lo});
   endfunction

   function automatic vec_t mk(input logic [3:0] vld, input int a0, a1, a2, a3,
                               input logic [31:0] d0,
                               input int n1, s10, s11, s12,
                               input int n2, s20, s21, s22,
                               input int n3, s30, s31, s32);
      vec_t v;
      v.vld = vld;
      v.addr[0] = ARF_SEL_W'(a0); v.addr[1] = ARF_SEL_W'(a1);
      v.addr[2] = ARF_SEL_W'(a2); v.addr[3] = ARF_SEL_W'(a3);
      v.dat[0] = d0; v.dat[1] = 32'hB; v.dat[2] = 32'hFFFF; v.dat[3] = 32'hD;
      v.n[0] = 2'(n1); v.n[1] = 2'(n2); v.n[2] = 2'(n3);
      v.src[0][0] = 2'(s10); v.src[0][1] = 2'(s11); v.src[0][2] = 2'(s12);
      v.src[1][0] = 2'(s20); v.src[1][1] = 2'(s21); v.src[1][2] = 2'(s22);
      v.src[2][0] = 2'(s30); v.src[2][1] = 2'(s31); v.src[2][2] = 2'(s32);
      return v;
   endfunction

   // Record accepted entries (r0 writes never reach a port), then step one cycle.
   task automatic tick();
      last_acc = bus.src_valid & bus.src_ready;
      for (int i = 0; i < NSRC; i++)
         if (last_acc[i] && bus.src_waddr[i] != '0)
            exp_q[i].push_back('{waddr: bus.src_waddr[i], wdata: bus.src_wdata[i]});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.src_valid = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < NSRC; i++) exp_q[i].delete();
      chk("rst_we", bus.we, 0);
      chk("rst_ready", bus.src_ready, {NSRC{1'b1}});
      chk("rst_busy", bus.busy, 0);
      chk("rst_port_zero", {bus.waddr, bus.wdata}, 0);
   endtask

   // Port monitor: legality of each cycle plus per-source order via the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < NWP; k++) begin
            if (bus.we[k]) begin
               int s;
               chk("wr_addr_nonzero", bus.waddr[k] != '0, 1);
               for (int j = 0; j < k; j++)
                  if (bus.we[j]) chk("port_addr_unique", bus.waddr[j] != bus.waddr[k], 1);
               s = int'(bus.wdata[k][DATA_W-1 -: 8]);
               if (s >= NSRC || exp_q[s].size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_write: port %0d addr %0d data %0h with nothing pending",
                           k, bus.waddr[k], bus.wdata[k]);
               end else begin
                  wb_req_t e;
                  e = exp_q[s].pop_front();
                  chk("sb_waddr", bus.waddr[k], e.waddr);
                  chk("sb_wdata", bus.wdata[k], e.wdata);
               end
            end else begin
               chk("idle_port_zero", {bus.waddr[k], bus.wdata[k]}, 0);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.src_valid = '0;
      bus.src_waddr = '0;
      bus.src_wdata = '0;

      //          vld     a0 a1 a2 a3  d0        c1             c2            c3
      vt_tab[0] = mk(4'b0001,  5, 0, 0, 0, 32'h1234, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
      vt_tab[1] = mk(4'b1111,  1, 2, 3, 4, 32'hA,    3, 0, 1, 2,  1, 3, 0, 0,  0, 0, 0, 0);
      vt_tab[2] = mk(4'b0011,  7, 7, 0, 0, 32'hA,    1, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0);
      vt_tab[3] = mk(4'b0100,  0, 0, 0, 0, 32'hA,    0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
      vt_tab[4] = mk(4'b1111,  0, 6, 0, 9, 32'hA,    2, 1, 3, 0,  0, 0, 0, 0,  0, 0, 0, 0);
      vt_tab[5] = mk(4'b1111,  8, 8, 8, 9, 32'hA,    2, 0, 3, 0,  1, 1, 0, 0,  1, 2, 0, 0);
      vt_tab[6] = mk(4'b1110,  0, 3, 3, 3, 32'hA,    1, 1, 0, 0,  1, 2, 0, 0,  1, 3, 0, 0);
      vt_tab[7] = mk(4'b1111, 10,11,12,10, 32'hA,    3, 0, 1, 2,  1, 3, 0, 0,  0, 0, 0, 0);
      vt_tab[8] = mk(4'b1111,  0, 0, 0, 0, 32'hA,    0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
      vt_tab[9] = mk(4'b1011, 31,31, 0,17, 32'hA,    2, 0, 3, 0,  1, 1, 0, 0,  0, 0, 0, 0);

      do_reset();
      mon_en = 1'b1;

      // Table: reset, inject one cycle, check the three following write cycles.
      for (int v = 0; v < 10; v++) begin
         vec_t vt;
         vt = vt_tab[v];
         do_reset();
         for (int s = 0; s < NSRC; s++) begin
            bus.src_valid[s] = vt.vld[s];
            bus.src_waddr[s] = vt.addr[s];
            bus.src_wdata[s] = tag(s, vt.dat[s]);
         end
         tick();
         bus.src_valid = '0;
         chk($sformatf("v%0d_latency", v), bus.we, 0);
         chk($sformatf("v%0d_busy_queued", v), bus.busy, vt.vld != '0);
         for (int c = 0; c < 3; c++) begin
            logic [NWP-1:0] ew;
            tick();
            ew = '0;
            for (int k = 0; k < int'(vt.n[c]); k++) ew[k] = 1'b1;
            chk($sformatf("v%0d_c%0d_we", v, c), bus.we, ew);
            for (int k = 0; k < int'(vt.n[c]); k++) begin
               int s;
               s = int'(vt.src[c][k]);
               chk($sformatf("v%0d_c%0d_waddr%0d", v, c, k), bus.waddr[k], vt.addr[s]);
               chk($sformatf("v%0d_c%0d_wdata%0d", v, c, k), bus.wdata[k], tag(s, vt.dat[s]));
            end
         end
         tick();
         chk($sformatf("v%0d_idle_busy", v), bus.busy, 0);
         chk($sformatf("v%0d_idle_ready", v), bus.src_ready, {NSRC{1'b1}});
      end

      // Backpressure: every source streams 12 writes; src1 must see ready drop.
      begin
         int idx [NSRC];
         int cyc;
         bit saw_stall;
         do_reset();
         for (int s = 0; s < NSRC; s++) idx[s] = 0;
         cyc = 0;
         saw_stall = 1'b0;
         while ((idx[0] < 12 || idx[1] < 12 || idx[2] < 12 || idx[3] < 12) && cyc < 200) begin
            for (int s = 0; s < NSRC; s++) begin
               bus.src_valid[s] = (idx[s] < 12);
               bus.src_waddr[s] = ARF_SEL_W'(1 + 4*s + (idx[s] % 4));
               bus.src_wdata[s] = tag(s, 32'(idx[s]));
            end
            if (bus.src_valid[1] && !bus.src_ready[1]) saw_stall = 1'b1;
            tick();
            for (int s = 0; s < NSRC; s++) if (last_acc[s]) idx[s]++;
            cyc++;
         end
         bus.src_valid = '0;
         chk("bp_within_budget", cyc < 200, 1);
         chk("bp_src1_backpressured", saw_stall, 1);
         cyc = 0;
         while (bus.busy && cyc < 50) begin
            tick();
            cyc++;
         end
         chk("bp_drained", bus.busy, 0);
         chk("bp_all_written", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
      end

      // Reset mid-burst: all sources pile onto r30, then reset discards the backlog.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < NSRC; s++) begin
            bus.src_valid[s] = 1'b1;
            bus.src_waddr[s] = ARF_SEL_W'(30);
            bus.src_wdata[s] = tag(s, 32'h100 + 32'(c));
         end
         tick();
      end
      chk("mid_busy_before_rst", bus.busy, 1);
      do_reset();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("mid_no_write_%0d", c), bus.we, 0);
      end
      chk("mid_busy_after", bus.busy, 0);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
